// File: rtl/wr_status_tracker.sv
// wr_status_tracker
// Write-domain receiver for the async FIFO read pointer. It synchronizes the
// Gray read pointer into wclk and converts it to binary. From that it derives
// the write-side occupancy and the almost-full flag. It also keeps a sticky
// flag for writes attempted while the FIFO is full.
module wr_status_tracker #(
   parameter int PTR_WIDTH   = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AF_THRESH   = 6
) (
   input  logic                 wclk,
   input  logic                 wrst_n,
   input  logic [PTR_WIDTH:0]   g_rptr,
   input  logic [PTR_WIDTH:0]   b_wptr,
   input  logic                 w_en,
   input  logic                 full,
   input  logic                 ovf_clr,
   output logic [PTR_WIDTH:0]   g_rptr_sync,
   output logic [PTR_WIDTH:0]   wr_level,
   output logic                 almost_full,
   output logic                 overflow
);

   localparam int PW1 = PTR_WIDTH + 1;
   localparam logic [PTR_WIDTH:0] LP_AF_THRESH = PW1'(AF_THRESH);

   logic [PTR_WIDTH:0] r_sync [SYNC_STAGES];
   logic [PTR_WIDTH:0] r_level;
   logic               r_almost_full;
   logic               r_overflow;

   logic [PTR_WIDTH:0] w_b_rptr_s;
   logic [PTR_WIDTH:0] w_level;
   logic               w_almost_full;
   logic               w_ovf_set;

   // Synchronizer chain: g_rptr feeds the first flop directly, with no logic in front.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         // NOTE: every sync stage is reset so that a reset mid-run restarts the
         // pointer view from 0. This array is a flop chain, not a RAM.
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments make each stage sample the previous
         // stage's old value. Blocking would collapse the chain into one flop.
         r_sync[0] <= g_rptr;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign g_rptr_sync = r_sync[SYNC_STAGES-1];

   // Gray to binary: b[i] is the XOR of all Gray bits from i up to the MSB.
   always_comb begin
      // NOTE: a default before the loop guarantees every bit is assigned, so no latch is inferred.
      w_b_rptr_s = '0;
      for (int i = 0; i <= PTR_WIDTH; i++) w_b_rptr_s[i] = ^(g_rptr_sync >> i);
   end

   // The modulo 2**(PTR_WIDTH+1) subtraction handles pointer wrap without a special case.
   assign w_level       = b_wptr - w_b_rptr_s;
   assign w_almost_full = (w_level >= LP_AF_THRESH);
   assign w_ovf_set     = w_en & full;

   // Level and almost_full registers, both updated on the same edge.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_level       <= '0;
         r_almost_full <= 1'b0;
      end else begin
         r_level       <= w_level;
         r_almost_full <= w_almost_full;
      end
   end

   // Sticky overflow: a write while full sets it, and set wins over clear on the same edge.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n)        r_overflow <= 1'b0;
      else if (w_ovf_set) r_overflow <= 1'b1;
      else if (ovf_clr)   r_overflow <= 1'b0;
   end

   assign wr_level    = r_level;
   assign almost_full = r_almost_full;
   assign overflow    = r_overflow;

endmodule

// File: tb/tb_wr_status_tracker.sv
// tb_wr_status_tracker
// Directed bench for wr_status_tracker. A vector table covers the
// steady-state level and almost_full results. Hand-written sequences cover
// reset, sync latency, overflow and async reset during operation.
module tb_wr_status_tracker;

   localparam int PW = 3;

   logic          wclk = 1'b0;
   logic          wrst_n;
   logic [PW:0]   g_rptr;
   logic [PW:0]   b_wptr;
   logic          w_en;
   logic          full;
   logic          ovf_clr;
   logic [PW:0]   g_rptr_sync;
   logic [PW:0]   wr_level;
   logic          almost_full;
   logic          overflow;

   int n_checks = 0;
   int n_errors = 0;

   wr_status_tracker #(.PTR_WIDTH(PW), .SYNC_STAGES(2), .AF_THRESH(6)) dut (
      .wclk        (wclk),
      .wrst_n      (wrst_n),
      .g_rptr      (g_rptr),
      .b_wptr      (b_wptr),
      .w_en        (w_en),
      .full        (full),
      .ovf_clr     (ovf_clr),
      .g_rptr_sync (g_rptr_sync),
      .wr_level    (wr_level),
      .almost_full (almost_full),
      .overflow    (overflow)
   );

   always #5 wclk = ~wclk;

   typedef struct {
      logic [PW:0] rptr_bin;
      logic [PW:0] wptr;
      logic        w_en;
      logic        full;
      logic [PW:0] exp_level;
      logic        exp_af;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [PW:0] bin2gray(input logic [PW:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".sync"},  32'(g_rptr_sync), 32'h0);
      check({name, ".level"}, 32'(wr_level),    32'h0);
      check({name, ".af"},    32'(almost_full), 32'h0);
      check({name, ".ovf"},   32'(overflow),    32'h0);
   endtask

   initial begin
      // Each row holds its inputs steady for 3 edges, which covers the
      // 2-stage sync plus the 1-edge level register.
      vecs[0] = '{4'd0,  4'd8, 1'b0, 1'b1, 4'd8, 1'b1}; // full alone does not set overflow
      vecs[1] = '{4'd0,  4'd5, 1'b1, 1'b0, 4'd5, 1'b0}; // w_en alone does not set overflow
      vecs[2] = '{4'd14, 4'd2, 1'b0, 1'b0, 4'd4, 1'b0}; // write pointer wrapped
      vecs[3] = '{4'd3,  4'd9, 1'b0, 1'b0, 4'd6, 1'b1}; // exactly at threshold
      vecs[4] = '{4'd4,  4'd9, 1'b0, 1'b0, 4'd5, 1'b0}; // one below threshold
      vecs[5] = '{4'd12, 4'd4, 1'b0, 1'b0, 4'd8, 1'b1}; // full depth across wrap
      vecs[6] = '{4'd7,  4'd7, 1'b0, 1'b0, 4'd0, 1'b0}; // empty
      vecs[7] = '{4'd15, 4'd0, 1'b0, 1'b0, 4'd1, 1'b0}; // both near wrap
      vecs[8] = '{4'd10, 4'd1, 1'b0, 1'b0, 4'd7, 1'b1}; // wrapped, almost full
      vecs[9] = '{4'd6,  4'd6, 1'b0, 1'b0, 4'd0, 1'b0}; // back to empty

      // Reset held low: outputs stay 0 while the clock toggles.
      wrst_n  = 1'b0;
      g_rptr  = 4'b0110;
      b_wptr  = 4'd5;
      w_en    = 1'b1;
      full    = 1'b1;
      ovf_clr = 1'b0;
      #2;
      check_all_zero("reset_async");
      for (int k = 0; k < 3; k++) begin
         tick();
         check_all_zero("reset_held");
      end

      // Sync latency: g_rptr 0 -> 1 appears after 2 edges, and the level follows on the 3rd.
      w_en   = 1'b0;
      full   = 1'b0;
      g_rptr = 4'b0000;
      b_wptr = 4'd3;
      wrst_n = 1'b1;
      tick();
      tick();
      check("lat.level_pre", 32'(wr_level), 32'd3);
      g_rptr = 4'b0001;
      tick();
      check("lat.sync_edge1", 32'(g_rptr_sync), 32'h0);
      tick();
      check("lat.sync_edge2", 32'(g_rptr_sync), 32'h1);
      check("lat.level_edge2", 32'(wr_level), 32'd3);
      tick();
      check("lat.level_edge3", 32'(wr_level), 32'd2);

      // Table-driven level and almost_full checks.
      for (int v = 0; v < 10; v++) begin
         g_rptr = bin2gray(vecs[v].rptr_bin);
         b_wptr = vecs[v].wptr;
         w_en   = vecs[v].w_en;
         full   = vecs[v].full;
         tick();
         tick();
         tick();
         check($sformatf("vec%0d.sync", v),  32'(g_rptr_sync), 32'(bin2gray(vecs[v].rptr_bin)));
         check($sformatf("vec%0d.level", v), 32'(wr_level),    32'(vecs[v].exp_level));
         check($sformatf("vec%0d.af", v),    32'(almost_full), 32'(vecs[v].exp_af));
         check($sformatf("vec%0d.ovf", v),   32'(overflow),    32'h0);
      end
      w_en = 1'b0;
      full = 1'b0;

      // Level drop is visible one edge after the write pointer changes.
      g_rptr = bin2gray(4'd0);
      b_wptr = 4'd8;
      tick();
      tick();
      tick();
      check("fill.level8", 32'(wr_level), 32'd8);
      check("fill.af1", 32'(almost_full), 32'd1);
      b_wptr = 4'd5;
      tick();
      check("fill.level5", 32'(wr_level), 32'd5);
      check("fill.af0", 32'(almost_full), 32'd0);

      // Overflow: set by w_en and full together, held when idle, set beats clear.
      w_en = 1'b1;
      full = 1'b1;
      tick();
      check("ovf.set", 32'(overflow), 32'd1);
      w_en = 1'b0;
      full = 1'b0;
      tick();
      tick();
      check("ovf.hold", 32'(overflow), 32'd1);
      w_en    = 1'b1;
      full    = 1'b1;
      ovf_clr = 1'b1;
      tick();
      check("ovf.set_wins", 32'(overflow), 32'd1);
      w_en = 1'b0;
      full = 1'b0;
      tick();
      check("ovf.clear", 32'(overflow), 32'd0);
      ovf_clr = 1'b0;
      tick();
      check("ovf.stay_clear", 32'(overflow), 32'd0);

      // Async reset mid-run: outputs clear before the next edge, and the sync restarts from 0.
      g_rptr = bin2gray(4'd1);
      b_wptr = 4'd6;
      w_en   = 1'b1;
      full   = 1'b1;
      tick();
      w_en = 1'b0;
      full = 1'b0;
      tick();
      tick();
      check("arst.pre_level", 32'(wr_level), 32'd5);
      check("arst.pre_ovf", 32'(overflow), 32'd1);
      check("arst.pre_sync", 32'(g_rptr_sync), 32'h1);
      wrst_n = 1'b0;
      #2;
      check_all_zero("arst.mid");
      #1;
      wrst_n = 1'b1;
      tick();
      check("arst.sync_edge1", 32'(g_rptr_sync), 32'h0);
      tick();
      check("arst.sync_edge2", 32'(g_rptr_sync), 32'h1);
      tick();
      check("arst.level", 32'(wr_level), 32'd5);
      check("arst.ovf", 32'(overflow), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
